data_ram_arbiter: RTL

Two-master arbiter that shares the single data_ram slave port between the CPU data-memory port (master 0) and a second requester such as a DMA or program loader (master 1). It sits between the masters and data_ram in the SOPC top level and replaces the direct CPU-to-RAM wiring. It uses a registered grant state machine with per-master request/acknowledge handshakes and a bounded burst lock. Read data is broadcast to both masters.

---
 rtl/data_ram_arbiter_pkg.sv | 20 ++
 rtl/data_ram_arbiter_pick.sv | 31 +++
 rtl/data_ram_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/data_ram_arbiter_pkg.sv
// Shared types and constants for the two-master data_ram arbiter.
// Holds the grant-state encodings, the master IDs and the reset value of
// the last-served pointer.
package data_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbOwn0 = 2'd1,
    ArbOwn1 = 2'd2
  } arb_state_e;

  typedef enum logic {
    ArbM0 = 1'b0,
    ArbM1 = 1'b1
  } arb_master_e;

  // After reset master 1 counts as "served last", so master 0 wins the first tie.
  localparam arb_master_e ArbLastRst = ArbM1;

endpackage

// File: rtl/data_ram_arbiter_pick.sv
// Combinational tie-break for the arbiter's IDLE state.
// Build option: define ARB_ROUND_ROBIN_EN to award a tie to the master that
// was not served last; without it master 0 always wins a tie.
module arb_pick
  import data_ram_arbiter_pkg::*;
(
  input  logic        req0,
  input  logic        req1,
  input  arb_master_e last,
  output arb_master_e winner
);

`ifdef ARB_ROUND_ROBIN_EN
  arb_master_e tie_winner;
  assign tie_winner = (last == ArbM0) ? ArbM1 : ArbM0;
`else
  arb_master_e tie_winner;
  logic        unused_last;
  assign tie_winner  = ArbM0;
  assign unused_last = last;
`endif

  // Winner among current requesters; defaults to master 0 when nobody asks.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    winner = ArbM0;
    if (req0 && req1) winner = tie_winner;
    else if (req1)    winner = ArbM1;
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Two-master arbiter in front of the single data_ram slave port.
// Master 0 is the CPU data port, master 1 a DMA / loader. A registered grant
// FSM hands the port to one master at a time, with a burst limit so a busy
// owner yields after MAX_BURST acks when the other master is waiting.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie-break in IDLE
// (see arb_pick); default is fixed priority to master 0.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic              m0_we_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,

  input  logic              m1_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic              m1_we_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,

  output logic [DATA_W-1:0] rdata_o,

  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [SEL_W-1:0]  ram_sel_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  localparam int CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST - 1);

  arb_state_e      state;
  logic [CntW-1:0] cnt;
  arb_master_e     last;
  arb_master_e     winner;

  logic own0;
  logic own1;
  logic cnt_at_max;

  arb_pick u_pick (
    .req0   (m0_req_i),
    .req1   (m1_req_i),
    .last   (last),
    .winner (winner)
  );

  assign cnt_at_max = (cnt == CntMax);

  // Grant FSM with burst counter and last-served pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state <= ArbIdle;
      cnt   <= '0;
      last  <= ArbLastRst;
    end else begin
      case (state)
        ArbIdle: begin
          if (m0_req_i || m1_req_i) begin
            state <= (winner == ArbM0) ? ArbOwn0 : ArbOwn1;
            cnt   <= '0;
            last  <= winner;
          end
        end
        ArbOwn0: begin
          if (!m0_req_i) begin
            cnt <= '0;
            if (m1_req_i) begin
              state <= ArbOwn1;
              last  <= ArbM1;
            end else begin
              state <= ArbIdle;
            end
          end else if (m1_req_i && cnt_at_max) begin
            state <= ArbOwn1;
            last  <= ArbM1;
            cnt   <= '0;
          end else if (!cnt_at_max) begin
            cnt <= cnt + CntW'(1);
          end
        end
        ArbOwn1: begin
          if (!m1_req_i) begin
            cnt <= '0;
            if (m0_req_i) begin
              state <= ArbOwn0;
              last  <= ArbM0;
            end else begin
              state <= ArbIdle;
            end
          end else if (m0_req_i && cnt_at_max) begin
            state <= ArbOwn0;
            last  <= ArbM0;
            cnt   <= '0;
          end else if (!cnt_at_max) begin
            cnt <= cnt + CntW'(1);
          end
        end
        default: begin
          state <= ArbIdle;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Ownership is masked while reset is asserted so an in-flight transfer is
  // neither acked nor written during the reset cycle.
  assign own0 = rst && (state == ArbOwn0);
  assign own1 = rst && (state == ArbOwn1);

  assign m0_ack_o = own0 && m0_req_i;
  assign m1_ack_o = own1 && m1_req_i;

  assign ram_ce_o = m0_ack_o || m1_ack_o;
  assign ram_we_o = (m0_ack_o && m0_we_i) || (m1_ack_o && m1_we_i);

  // Slave address/select/data follow the owner; all zero when nobody owns the port.
  always_comb begin
    ram_addr_o  = '0;
    ram_sel_o   = '0;
    ram_wdata_o = '0;
    if (own0) begin
      ram_addr_o  = m0_addr_i;
      ram_sel_o   = m0_sel_i;
      ram_wdata_o = m0_wdata_i;
    end else if (own1) begin
      ram_addr_o  = m1_addr_i;
      ram_sel_o   = m1_sel_i;
      ram_wdata_o = m1_wdata_i;
    end
  end

  // Read data is broadcast; each master qualifies it with its own ack.
  assign rdata_o = ram_data_i;

endmodule
